mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single synchronous RAM.
// Round-robin on ties, one access in flight, optional wait states per access.
//
// state  | meaning
// IDLE   | sampling requests, no access in flight
// ACCESS | latched address/data driven to RAM for WAIT_CYCLES+1 cycles
// RESP   | ack to the granted port; read data flows through from RAM

module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,

  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,

  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic [7:0] dbg_rdata,
  output logic       dbg_ack,

  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,

  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DBG = 1'b1;
  localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYCLES);

  state_t     state, state_nxt;
  logic [1:0] wait_cnt, wait_cnt_nxt;
  logic       last_grant;
  logic       grant;
  logic       lat_we;
  logic [7:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [7:0] cpu_rdata_q;
  logic [7:0] dbg_rdata_q;

  logic       take;
  logic       pick;
  logic       access_last;

  // Arbitration: on a tie the port that did not win last time goes first.
  always_comb begin
    take = 1'b0;
    pick = GRANT_CPU;
    if (cpu_req && dbg_req) begin
      take = 1'b1;
      pick = (last_grant == GRANT_CPU) ? GRANT_DBG : GRANT_CPU;
    end else if (cpu_req) begin
      take = 1'b1;
      pick = GRANT_CPU;
    end else if (dbg_req) begin
      take = 1'b1;
      pick = GRANT_DBG;
    end
  end

  assign access_last = (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        wait_cnt_nxt = 2'd0;
        if (take) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (access_last) begin
          state_nxt    = RESP;
          wait_cnt_nxt = 2'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 2'd1;
        end
      end
      RESP: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 2'd0;
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 2'd0;
      last_grant  <= GRANT_DBG;
      grant       <= GRANT_CPU;
      lat_we      <= 1'b0;
      lat_addr    <= 8'h00;
      lat_wdata   <= 8'h00;
      cpu_rdata_q <= 8'h00;
      dbg_rdata_q <= 8'h00;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == IDLE && take) begin
        grant      <= pick;
        last_grant <= pick;
        if (pick == GRANT_DBG) begin
          lat_we    <= dbg_we;
          lat_addr  <= dbg_addr;
          lat_wdata <= dbg_wdata;
        end else begin
          lat_we    <= cpu_we;
          lat_addr  <= cpu_addr;
          lat_wdata <= cpu_wdata;
        end
      end
      // Read data is valid from RAM throughout RESP; keep it for the port.
      if (state == RESP && !lat_we) begin
        if (grant == GRANT_DBG) begin
          dbg_rdata_q <= mem_rdata;
        end else begin
          cpu_rdata_q <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    cpu_rdata = cpu_rdata_q;
    dbg_rdata = dbg_rdata_q;
    busy      = (state != IDLE);
    if (state == ACCESS) begin
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_we    = lat_we && access_last;
    end
    if (state == RESP) begin
      if (grant == GRANT_DBG) begin
        dbg_ack = 1'b1;
        if (!lat_we) begin
          dbg_rdata = mem_rdata;
        end
      end else begin
        cpu_ack = 1'b1;
        if (!lat_we) begin
          cpu_rdata = mem_rdata;
        end
      end
    end
  end

endmodule
